recirculation_launch_a: RTL

Source-domain launch controller placed directly upstream of the recirculation-mux CDC stage, clocked in domain A. Buffers words from a valid/ready producer in a small FIFO, presents each word on a registered data bus and fires a one-cycle launch pulse. It then holds the data stable for a programmable guard interval, so the downstream toggle synchronizer and domain-B capture register always sample a settled bus and never see back-to-back pulses.

---
 rtl/recirculation_launch_a.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/recirculation_launch_a.sv
// recirculation_launch_a: domain-A launch controller feeding the recirculation-mux
// CDC stage. Words from a valid/ready producer are queued in a small FIFO, then
// presented one at a time on a registered bus with a one-cycle launch pulse. The
// bus is held for G_HOLD cycles after the pulse so domain B samples settled data.
//
// Handshake: a word is transferred on a rising i_clk_A edge where i_valid and
// o_ready are both high. o_ready depends only on registered occupancy. The
// producer must hold i_valid and i_data until the transfer edge.
//
// Optional feature: define RECIRC_LAUNCH_CNT_EN to add o_launch_cnt, a
// saturating 16-bit count of launches.
//
// FSM state is held in state_q (type state_t) so checkers can bind to it.
module recirculation_launch_a #(
   parameter int G_WIDTH = 4,
   parameter int G_DEPTH = 4,
   parameter int G_HOLD  = 6
) (
   input  logic                       i_clk_A,
   input  logic                       i_rst_A,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic [G_WIDTH-1:0]         i_data,
   output logic                       o_pulse_A,
   output logic [G_WIDTH-1:0]         o_data_A,
   output logic                       o_busy,
   output logic [$clog2(G_DEPTH):0]   o_level
`ifdef RECIRC_LAUNCH_CNT_EN
   ,
   output logic [15:0]                o_launch_cnt
`endif
);

   localparam int PTR_W = $clog2(G_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = (G_HOLD > 1) ? $clog2(G_HOLD) : 1;
   localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(G_DEPTH);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(G_HOLD - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t             state_q;
   logic [G_WIDTH-1:0] mem_q [G_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [LVL_W-1:0]   level_q;
   logic               have_word_q;
   logic [CNT_W-1:0]   hold_cnt_q;
   logic               push;
   logic               pop;

   // The launch decision uses have_word_q, a registered "FIFO was non-empty"
   // flag, so a freshly accepted word launches two edges after acceptance while
   // a backlogged FIFO still launches after a single IDLE cycle.
   assign o_ready = (level_q != FULL_LVL);
   assign o_level = level_q;
   assign push    = i_valid && o_ready;
   assign pop     = (state_q == ST_IDLE) && have_word_q && (level_q != '0);

   // FIFO storage: written on every accepted word, no reset needed
   always_ff @(posedge i_clk_A) begin
      if (push) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of two)
   always_ff @(posedge i_clk_A or posedge i_rst_A) begin
      if (i_rst_A) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         have_word_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
         have_word_q <= (level_q != '0);
      end
   end

   // Launch FSM with registered pulse, data and busy outputs
   always_ff @(posedge i_clk_A or posedge i_rst_A) begin
      if (i_rst_A) begin
         state_q    <= ST_IDLE;
         o_pulse_A  <= 1'b0;
         o_data_A   <= '0;
         o_busy     <= 1'b0;
         hold_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  o_data_A  <= mem_q[rd_ptr_q];
                  o_pulse_A <= 1'b1;
                  o_busy    <= 1'b1;
                  state_q   <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               o_pulse_A  <= 1'b0;
               hold_cnt_q <= HOLD_LOAD;
               state_q    <= ST_HOLD;
            end
            ST_HOLD: begin
               if (hold_cnt_q == '0) begin
                  o_busy  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  hold_cnt_q <= hold_cnt_q - CNT_W'(1);
               end
            end
            default: begin
               o_pulse_A <= 1'b0;
               o_busy    <= 1'b0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef RECIRC_LAUNCH_CNT_EN
   logic [15:0] launch_cnt_q;

   // Saturating count of launches, bumped on each IDLE->LAUNCH transition
   always_ff @(posedge i_clk_A or posedge i_rst_A) begin
      if (i_rst_A) begin
         launch_cnt_q <= '0;
      end else if (pop && (launch_cnt_q != 16'hFFFF)) begin
         launch_cnt_q <= launch_cnt_q + 16'd1;
      end
   end

   assign o_launch_cnt = launch_cnt_q;
`endif

endmodule
